// File: rtl/bcd_mod_counter.sv
// Parametrised cascadable BCD counter with range-checked preset, time-setting adjust
// and terminal-count carry. Down-counting with borrow is built only when BCD_CNT_DOWN_EN is defined.
module bcd_mod_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MODULUS = 60,
    parameter int unsigned RST_VAL = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  adj_i,
    input  logic                  dir_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   din_i,
    output logic [4*DIGITS-1:0]   dout_o,
    output logic                  co_o,
    output logic                  load_err_o
);

    localparam int unsigned W = 4 * DIGITS;

    // Elaboration-time sanity checks on the parameter set.
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be in 1..4");
    end
    if (MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..10**DIGITS");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("bcd_mod_counter: RST_VAL must be below MODULUS");
    end

    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = value;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    logic [W-1:0] dout_q, dout_d;
    logic         load_err_q, load_err_d;
    logic         down_c;
    logic         term_c;
    logic         din_ok_c;
    logic [W-1:0] up_c;
    logic [W-1:0] step_c;

    // For well-formed BCD, packed-nibble unsigned order equals decimal order.
    always_comb begin
        din_ok_c = (din_i <= MAX_BCD);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (din_i[4*i +: 4] > 4'd9) begin
                din_ok_c = 1'b0;
            end
        end
    end

    assign up_c = (dout_q == MAX_BCD) ? '0 : bcd_inc(dout_q);

`ifdef BCD_CNT_DOWN_EN
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] dn_c;

    assign down_c = dir_i;
    assign dn_c   = (dout_q == '0) ? MAX_BCD : bcd_dec(dout_q);
    assign step_c = down_c ? dn_c : up_c;
    assign term_c = down_c ? (dout_q == '0) : (dout_q == MAX_BCD);
`else
    logic dir_unused;

    assign dir_unused = dir_i;
    assign down_c     = 1'b0;
    assign step_c     = up_c;
    assign term_c     = (dout_q == MAX_BCD);
`endif

    // Next state: load beats adjust beats enable; reset is applied in the register.
    always_comb begin
        dout_d     = dout_q;
        load_err_d = load_err_q;
        if (load_i) begin
            if (din_ok_c) begin
                dout_d     = din_i;
                load_err_d = 1'b0;
            end else begin
                dout_d     = '0;
                load_err_d = 1'b1;
            end
        end else if (adj_i || en_i) begin
            dout_d = step_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q     <= RST_BCD;
            load_err_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            load_err_q <= load_err_d;
        end
    end

    // Carry is combinational so a cascaded stage steps on the same edge as this wrap.
    assign co_o       = en_i & ~adj_i & ~load_i & ~rst_i & term_c;
    assign dout_o     = dout_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter: directed table, hand sequences, a 60/60/24 cascade
// and random stimulus against an integer-arithmetic reference model.
module tb_bcd_mod_counter;

    logic        clk;
    logic        rst, en, adj, dir, load;
    logic [11:0] din;
    logic [7:0]  dout_a, dout_b, dout_d;
    logic [11:0] dout_c;
    logic        co_a, co_b, co_c, co_d;
    logic        err_a, err_b, err_c, err_d;

    logic        c_rst, c_en, c_load;
    logic [7:0]  c_din_s, c_din_m, c_din_h;
    logic [7:0]  dout_s, dout_m, dout_h;
    logic        co_s, co_m, co_h;
    logic        err_s, err_m, err_h;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per main instance (A: 60, B: 24, C: 3-digit 250, D: 60 rst 30).
    int mval[4];
    bit merr[4];
    int mmod[4] = '{60, 24, 250, 60};
    int mdig[4] = '{2, 2, 3, 2};
    int mrst[4] = '{0, 0, 123, 30};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RST_VAL(0)) u_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .adj_i(adj), .dir_i(dir), .load_i(load),
        .din_i(din[7:0]), .dout_o(dout_a), .co_o(co_a), .load_err_o(err_a));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .RST_VAL(0)) u_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .adj_i(adj), .dir_i(dir), .load_i(load),
        .din_i(din[7:0]), .dout_o(dout_b), .co_o(co_b), .load_err_o(err_b));
    bcd_mod_counter #(.DIGITS(3), .MODULUS(250), .RST_VAL(123)) u_c (
        .clk_i(clk), .rst_i(rst), .en_i(en), .adj_i(adj), .dir_i(dir), .load_i(load),
        .din_i(din), .dout_o(dout_c), .co_o(co_c), .load_err_o(err_c));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RST_VAL(30)) u_d (
        .clk_i(clk), .rst_i(rst), .en_i(en), .adj_i(adj), .dir_i(dir), .load_i(load),
        .din_i(din[7:0]), .dout_o(dout_d), .co_o(co_d), .load_err_o(err_d));

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RST_VAL(0)) u_sec (
        .clk_i(clk), .rst_i(c_rst), .en_i(c_en), .adj_i(1'b0), .dir_i(1'b0), .load_i(c_load),
        .din_i(c_din_s), .dout_o(dout_s), .co_o(co_s), .load_err_o(err_s));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RST_VAL(0)) u_min (
        .clk_i(clk), .rst_i(c_rst), .en_i(co_s), .adj_i(1'b0), .dir_i(1'b0), .load_i(c_load),
        .din_i(c_din_m), .dout_o(dout_m), .co_o(co_m), .load_err_o(err_m));
    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .RST_VAL(0)) u_hr (
        .clk_i(clk), .rst_i(c_rst), .en_i(co_m), .adj_i(1'b0), .dir_i(1'b0), .load_i(c_load),
        .din_i(c_din_h), .dout_o(dout_h), .co_o(co_h), .load_err_o(err_h));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int value, input int n);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic bit model_down();
`ifdef BCD_CNT_DOWN_EN
        return dir;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_co(input int k);
        int term;
        term = model_down() ? 0 : mmod[k] - 1;
        return en && !adj && !load && !rst && (mval[k] == term);
    endfunction

    task automatic model_next(input int k);
        int          bin;
        bit          ok;
        logic [3:0]  nb;
        if (rst) begin
            mval[k] = mrst[k];
            merr[k] = 1'b0;
        end else if (load) begin
            bin = 0;
            ok  = 1'b1;
            for (int i = mdig[k] - 1; i >= 0; i--) begin
                nb = din[4*i +: 4];
                if (nb > 4'd9) ok = 1'b0;
                bin = bin * 10 + int'(nb);
            end
            if (ok && bin < mmod[k]) begin
                mval[k] = bin;
                merr[k] = 1'b0;
            end else begin
                mval[k] = 0;
                merr[k] = 1'b1;
            end
        end else if (adj || en) begin
            if (model_down()) mval[k] = (mval[k] + mmod[k] - 1) % mmod[k];
            else              mval[k] = (mval[k] + 1) % mmod[k];
        end
    endtask

    function automatic logic [15:0] get_dout(input int k);
        case (k)
            0:       return 16'(dout_a);
            1:       return 16'(dout_b);
            2:       return 16'(dout_c);
            default: return 16'(dout_d);
        endcase
    endfunction

    function automatic logic get_co(input int k);
        case (k)
            0:       return co_a;
            1:       return co_b;
            2:       return co_c;
            default: return co_d;
        endcase
    endfunction

    function automatic logic get_err(input int k);
        case (k)
            0:       return err_a;
            1:       return err_b;
            2:       return err_c;
            default: return err_d;
        endcase
    endfunction

    // One clock of stimulus on the shared inputs; co checked mid-cycle, registers after the edge.
    task automatic apply(input bit r, input bit ld, input bit aj, input bit e, input bit d,
                         input logic [11:0] dn, output logic [3:0] co_seen);
        rst = r; load = ld; adj = aj; en = e; dir = d; din = dn;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            co_seen[k] = get_co(k);
            check($sformatf("co[%0d]", k), 16'(get_co(k)), 16'(model_co(k)));
        end
        for (int k = 0; k < 4; k++) model_next(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dout[%0d]", k), get_dout(k), to_bcd(mval[k], mdig[k]));
            check($sformatf("load_err[%0d]", k), 16'(get_err(k)), 16'(merr[k]));
        end
        rst = 0; load = 0; adj = 0; en = 0; dir = 0;
    endtask

    typedef struct {
        bit          rst;
        bit          load;
        bit          adj;
        bit          en;
        logic [11:0] din;
        logic [7:0]  exp_dout;
        bit          exp_co;
        bit          exp_err;
    } vec_t;

    vec_t        tbl[18];
    logic [3:0]  cs;
    int          co_cnt;

    initial begin
        rst = 1; load = 0; adj = 0; en = 0; dir = 0; din = '0;
        c_rst = 1; c_load = 0; c_en = 0; c_din_s = '0; c_din_m = '0; c_din_h = '0;
        for (int k = 0; k < 4; k++) begin
            mval[k] = mrst[k];
            merr[k] = 1'b0;
        end

        // Expected values for instance A (mod 60, reset 0).
        tbl[0]  = '{0, 1, 0, 0, 12'h058, 8'h58, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 12'h000, 8'h59, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 12'h000, 8'h00, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 12'h03A, 8'h00, 0, 1};
        tbl[4]  = '{0, 0, 0, 1, 12'h000, 8'h01, 0, 1};
        tbl[5]  = '{0, 1, 0, 0, 12'h060, 8'h00, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 12'h009, 8'h09, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 12'h000, 8'h10, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 12'h059, 8'h59, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 12'h000, 8'h00, 0, 0};
        tbl[10] = '{0, 1, 0, 1, 12'h059, 8'h59, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 12'h030, 8'h00, 0, 0};
        tbl[12] = '{0, 1, 0, 0, 12'h199, 8'h00, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 12'h000, 8'h01, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 12'h000, 8'h00, 0, 0};
        tbl[15] = '{0, 1, 0, 0, 12'h059, 8'h59, 0, 0};
        tbl[16] = '{0, 0, 1, 0, 12'h000, 8'h00, 0, 0};
        tbl[17] = '{0, 0, 0, 1, 12'h000, 8'h01, 0, 0};

        @(posedge clk);
        #1;

        // Cascade 23:59:59 -> 00:00:00 on a single seconds enable.
        c_rst = 0; c_load = 1; c_din_s = 8'h59; c_din_m = 8'h59; c_din_h = 8'h23;
        @(posedge clk);
        #1;
        c_load = 0;
        check("cas_preload", {dout_h, dout_m}, 16'h2359);
        c_en = 1;
        @(negedge clk);
        check("cas_co_chain", 16'({co_s, co_m, co_h}), 16'b111);
        @(posedge clk);
        #1;
        c_en = 0;
        check("cas_wrap_hm", {dout_h, dout_m}, 16'h0000);
        check("cas_wrap_s", 16'(dout_s), 16'h0000);
        c_en = 1;
        @(negedge clk);
        check("cas_co_idle", 16'({co_s, co_m, co_h}), 16'b000);
        @(posedge clk);
        #1;
        c_en = 0;
        check("cas_next", {dout_s, dout_m}, 16'h0100);

        // Reset state, including the RST_VAL=30 build.
        apply(1, 0, 0, 0, 0, 12'h000, cs);
        check("rst_val30", 16'(dout_d), 16'h0030);
        check("rst_val123", 16'(dout_c), 16'h0123);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].rst, tbl[i].load, tbl[i].adj, tbl[i].en, 1'b0, tbl[i].din, cs);
            check($sformatf("tbl%0d_co", i), 16'(cs[0]), 16'(tbl[i].exp_co));
            check($sformatf("tbl%0d_dout", i), 16'(dout_a), 16'(tbl[i].exp_dout));
            check($sformatf("tbl%0d_err", i), 16'(err_a), 16'(tbl[i].exp_err));
        end

        // Full mod-60 cycle: 61 enables from reset, co exactly once.
        apply(1, 0, 0, 0, 0, 12'h000, cs);
        co_cnt = 0;
        for (int i = 0; i < 61; i++) begin
            apply(0, 0, 0, 1, 0, 12'h000, cs);
            if (cs[0]) co_cnt++;
            if (i == 59) check("cyc60_zero", 16'(dout_a), 16'h0000);
        end
        check("cyc60_co_count", 16'(co_cnt), 16'd1);
        check("cyc60_end", 16'(dout_a), 16'h0001);

        // Hours stage: 23 wraps with co on the enable after load.
        apply(0, 1, 0, 0, 0, 12'h023, cs);
        apply(0, 0, 0, 1, 0, 12'h000, cs);
        check("hr_co", 16'(cs[1]), 16'd1);
        check("hr_wrap", 16'(dout_b), 16'h0000);
        apply(0, 1, 0, 0, 0, 12'h024, cs);
        check("hr_ld24", {dout_b, 7'd0, err_b}, 16'h0001);
        apply(0, 1, 0, 0, 0, 12'h01A, cs);
        check("hr_ld1A", {dout_b, 7'd0, err_b}, 16'h0001);

        // Direction handling.
        apply(0, 1, 0, 0, 0, 12'h001, cs);
        apply(0, 0, 0, 1, 1, 12'h000, cs);
`ifdef BCD_CNT_DOWN_EN
        check("dn_01_00", {dout_a, 7'd0, cs[0]}, 16'h0000);
        apply(0, 0, 0, 1, 1, 12'h000, cs);
        check("dn_00_59", {dout_a, 7'd0, cs[0]}, 16'h5901);
        apply(0, 1, 0, 0, 0, 12'h010, cs);
        apply(0, 0, 0, 1, 1, 12'h000, cs);
        check("dn_10_09", 16'(dout_a), 16'h0009);
        apply(0, 1, 0, 0, 0, 12'h005, cs);
        apply(0, 0, 0, 1, 1, 12'h000, cs);
        check("dir_05", 16'(dout_a), 16'h0004);
`else
        check("nodn_01_02", {dout_a, 7'd0, cs[0]}, 16'h0200);
        apply(0, 1, 0, 0, 0, 12'h005, cs);
        apply(0, 0, 0, 1, 1, 12'h000, cs);
        check("dir_05", 16'(dout_a), 16'h0006);
`endif

        // 3-digit carry across two nibbles.
        apply(0, 1, 0, 0, 0, 12'h199, cs);
        apply(0, 0, 0, 1, 0, 12'h000, cs);
        check("c3_carry", 16'(dout_c), 16'h0200);

        // Randomized stimulus against the model.
        for (int i = 0; i < 500; i++) begin
            apply(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? 12'(to_bcd(int'($urandom_range(0, 299)), 3))
                                              : 12'($urandom),
                  cs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised synchronous BCD counter with a configurable digit count and modulus. It replaces the fixed mod-60 / mod-24 counter chains in the multifunction digital clock. Adds synchronous preset load with range checking, a time-setting adjust input and optional down-counting. Stages cascade by feeding one instance's `co` into the next instance's `en`, for example seconds → minutes → hours.

## Interface
- `DIGITS`, default 2: number of BCD digits; range 1..4.
- `MODULUS`, default 60: count cycle length; range 2..10^DIGITS.
- `RST_VAL`, default 0: binary value loaded on reset; must be < MODULUS; stored as BCD.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-high.
- `en` in 1: count enable; one step per cycle while high.
- `adj` in 1: adjust; one step per cycle while high, independent of `en`, never produces `co`.
- `dir` in 1: 0 = up, 1 = down. Only honoured with `BCD_CNT_DOWN_EN`.
- `load` in 1: synchronous preset from `din`.
- `din` in 4*DIGITS: BCD preset value, most-significant digit in the top nibble.
- `dout` out 4*DIGITS: registered BCD count, most-significant digit in the top nibble.
- `co` out 1: terminal-count carry or borrow, combinational.
- `load_err` out 1: registered flag for a rejected preset.

## Operation
- Priority at each rising edge: `rst` > `load` > `adj` > `en`. At most one action per cycle.
- `rst`:
  - `dout` ← BCD(RST_VAL).
  - `load_err` ← 0.
- `load`:
  - If every nibble of `din` is ≤ 9 and its value is < MODULUS: `dout` ← `din`, `load_err` ← 0.
  - Otherwise: `dout` ← 0, `load_err` ← 1.
- `adj` or `en` step, up direction:
  - From MODULUS-1, wrap to 0.
  - Otherwise add 1 in decimal: a digit at 9 becomes 0 and carries into the next digit.
- Step, down direction (macro only):
  - From 0, wrap to MODULUS-1.
  - Otherwise subtract 1 in decimal: a digit at 0 becomes 9 and borrows from the next digit.
- `load_err` is held until the next `rst` or a valid `load`. A step does not clear it.
- `co` = `en` & ~`adj` & ~`load` & ~`rst` & terminal.
  - Terminal is `dout` == MODULUS-1 when counting up.
  - Terminal is `dout` == 0 when counting down.
- `adj` has priority over `en` in the same cycle. Result: a single step with `co` = 0, so adjusting minutes never advances hours.
- `dout` never holds a value ≥ MODULUS or a nibble > 9, under any input sequence.

## Timing
- Reset values:
  - `dout` = BCD(RST_VAL).
  - `load_err` = 0.
  - `co` = 0 while `rst` is high.
- Step latency: `dout` updates at the first rising edge where `en` or `adj` is sampled high.
- `co` is high in the same cycle as the enabling `en` while `dout` is terminal. A cascaded next stage therefore steps on the same edge on which this stage wraps.
- `load` latency is 1 cycle for both `dout` and `load_err`.
- `rst` asserted mid-operation overrides `load`, `adj` and `en` in that cycle. `co` is forced low combinationally.
- `dir` is sampled every cycle. A change takes effect on the next step and on `co` immediately.
- The combinational `co` chain across N cascaded stages is the critical path. N ≤ 4 must meet timing at the system clock.

## Configuration
- `BCD_CNT_DOWN_EN` defined:
  - `dir` = 1 selects down-counting with borrow.
  - `co` flags the borrow from 0 while counting down.
- `BCD_CNT_DOWN_EN` undefined:
  - `dir` port remains but is ignored; the counter always counts up.
  - No down-count logic is synthesised.

## Test plan
- Default parameters, `en` held high for 61 cycles after reset → `dout` reaches 0x59, then 0x00. `co` is high only in the cycle where `dout` = 0x59.
- DIGITS=2, MODULUS=24 (hours):
  - Load 0x23, then pulse `en` → `dout` = 0x00 with `co` = 1 in the load+1 cycle.
  - Load 0x24 → `dout` = 0x00, `load_err` = 1.
  - Load 0x1A → `dout` = 0x00, `load_err` = 1.
- `dout` = 0x59, `adj` and `en` both high for one cycle → `dout` = 0x00, `co` = 0 throughout. `en` alone from 0x09 → 0x10.
- `rst` and `load` (`din` = 0x30) asserted together while counting → `dout` = BCD(RST_VAL), `load_err` = 0. A RST_VAL=30 build gives `dout` = 0x30 after reset.
- With `BCD_CNT_DOWN_EN`, MODULUS=60, `dir` = 1, `en` high from 0x01:
  - Sequence 0x01 → 0x00 → 0x59; `co` is high in the 0x00 cycle.
  - Down-step from 0x10 → 0x09.
- Without the macro, `dir` = 1 and `en` high from 0x05 → `dout` = 0x06 (`dir` ignored).
- Cascade of three instances (60/60/24) from 23:59:59, one `en` pulse on the seconds stage → all three stages read 00 on the same edge.
